// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
// Grant policy helper keeps the top-level decode short.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

  localparam int unsigned DEF_ADDR_W        = 32;
  localparam int unsigned DEF_DATA_W        = 32;
  localparam int unsigned DEF_MAX_DM_STREAK = 4;
  localparam int unsigned DEF_TIMEOUT       = 64;

  // DM wins unless IF has waited through a full DM streak
  function automatic logic dm_wins(
    input logic if_req,
    input logic dm_req,
    input logic at_max
  );
    return dm_req & ~(if_req & at_max);
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts cycles spent in ACCESS and flags expiry
// once TIMEOUT-1 is reached; saturates there until cleared.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and DM accesses onto one single-port memory with
// DM priority, a bounded IF starvation guard and an access watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = DEF_ADDR_W,
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned MAX_DM_STREAK = DEF_MAX_DM_STREAK,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              err_o,
  output logic              stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int unsigned SW = $clog2(MAX_DM_STREAK + 1);

  state_t        state;
  gnt_t          owner;
  logic [SW-1:0] streak;
  logic          at_max;
  logic          pick_dm;
  logic          grant;
  logic          wd_expired;

  assign at_max  = (streak == SW'(MAX_DM_STREAK));
  assign pick_dm = dm_wins(if_req_i, dm_req_i, at_max);
  assign grant   = (state == IDLE) && (if_req_i || dm_req_i);
  assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (grant),
    .enable  (state == ACCESS),
    .expired (wd_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      owner       <= GNT_IF;
      streak      <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      err_o       <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      err_o    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            mem_en_o <= 1'b1;
            state    <= ACCESS;
            if (pick_dm) begin
              owner       <= GNT_DM;
              mem_we_o    <= dm_we_i;
              mem_addr_o  <= dm_addr_i;
              mem_wdata_o <= dm_wdata_i;
              if (!if_req_i)   streak <= '0;
              else if (!at_max) streak <= streak + 1'b1;
            end else begin
              owner      <= GNT_IF;
              mem_we_o   <= 1'b0;
              mem_addr_o <= if_addr_i;
              streak     <= '0;
            end
          end
        end
        ACCESS: begin
          if (mem_ack_i) begin
            mem_en_o <= 1'b0;
            state    <= RESP;
            if (owner == GNT_IF) begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= mem_rdata_i;
            end else begin
              dm_ack_o <= 1'b1;
              if (!mem_we_o) dm_rdata_o <= mem_rdata_i;
            end
          end else if (wd_expired) begin
            // abort: ack with error, read data regs untouched
            mem_en_o <= 1'b0;
            state    <= RESP;
            err_o    <= 1'b1;
            if_ack_o <= (owner == GNT_IF);
            dm_ack_o <= (owner == GNT_DM);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a behavioural
// memory, grant-order reference and per-requester expectation queues.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 64;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        err_o;
  logic        stall_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  int checks   = 0;
  int failures = 0;

  exp_t if_exp_q[$];
  exp_t dm_exp_q[$];
  int   if_lat_q[$];
  int   dm_lat_q[$];
  bit   gnt_log[$];

  logic [31:0] if_prev = '0;
  logic [31:0] dm_prev = '0;
  logic        p_if = 1'b0;
  logic        p_dm = 1'b0;
  int          ref_streak = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAXS), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .err_o(err_o), .stall_o(stall_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // requests as seen by the arbiter at the edge that granted
  always @(posedge clk) begin
    p_if <= if_req_i;
    p_dm <= dm_req_i;
  end

  // Reference grant decision, checked when an access starts
  task automatic grant_check(output int lat);
    bit own_dm;
    bit ok;
    checks++;
    if (!p_if && !p_dm) begin
      failures++;
      $display("FAIL grant_spurious: access started with no request");
      lat = 0;
      return;
    end
    if (p_if && p_dm) own_dm = (ref_streak != MAXS);
    else              own_dm = p_dm;
    if (own_dm) ref_streak = p_if ? ((ref_streak < MAXS) ? ref_streak + 1 : MAXS) : 0;
    else        ref_streak = 0;
    gnt_log.push_back(own_dm);
    if (own_dm) begin
      ok = (mem_addr_o === dm_addr_i) && (mem_we_o === dm_we_i) &&
           (!dm_we_i || mem_wdata_o === dm_wdata_i);
    end else begin
      ok = (mem_addr_o === if_addr_i) && (mem_we_o === 1'b0);
    end
    if (!ok) begin
      failures++;
      $display("FAIL grant_%s: got addr=%h we=%b wdata=%h want addr=%h we=%b",
               own_dm ? "dm" : "if", mem_addr_o, mem_we_o, mem_wdata_o,
               own_dm ? dm_addr_i : if_addr_i, own_dm ? dm_we_i : 1'b0);
    end
    if (own_dm) lat = (dm_lat_q.size() > 0) ? dm_lat_q.pop_front() : 0;
    else        lat = (if_lat_q.size() > 0) ? if_lat_q.pop_front() : 0;
  endtask

  // Behavioural memory: per-access latency, -1 = never ack (then a late ack)
  initial begin
    int  mcnt;
    int  late;
    bit  busy;
    mcnt = 0; late = 0; busy = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack_i = 1'b0;
      mem_rdata_i = $urandom;
      if (late > 0) begin
        mem_ack_i = 1'b1;
        late--;
      end else if (mem_en_o) begin
        if (!busy) begin
          busy = 1;
          grant_check(mcnt);
        end
        if (mcnt == 0) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = memf(mem_addr_o);
          busy = 0;
        end else if (mcnt > 0) begin
          mcnt--;
        end
      end else if (busy) begin
        busy = 0;
        mem_ack_i = 1'b1;
        late = 1;
      end
    end
  end

  // Monitor: pops expectations on every ack
  initial begin
    exp_t e;
    logic exp_stall;
    forever begin
      @(negedge clk);
      exp_stall = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);
      checks++;
      if (stall_o !== exp_stall) begin
        failures++;
        $display("FAIL stall: got %b want %b", stall_o, exp_stall);
      end
      if (rst_i) continue;
      if (if_ack_o && dm_ack_o) begin
        checks++; failures++;
        $display("FAIL dual_ack: got both acks want one");
      end
      if (if_ack_o) begin
        checks++;
        if (if_exp_q.size() == 0) begin
          failures++;
          $display("FAIL if_ack: got unexpected ack want none");
        end else begin
          e = if_exp_q.pop_front();
          if (if_rdata_o !== e.rdata || err_o !== e.err) begin
            failures++;
            $display("FAIL if_resp: got rdata=%h err=%b want rdata=%h err=%b",
                     if_rdata_o, err_o, e.rdata, e.err);
          end
        end
      end
      if (dm_ack_o) begin
        checks++;
        if (dm_exp_q.size() == 0) begin
          failures++;
          $display("FAIL dm_ack: got unexpected ack want none");
        end else begin
          e = dm_exp_q.pop_front();
          if (dm_rdata_o !== e.rdata || err_o !== e.err) begin
            failures++;
            $display("FAIL dm_resp: got rdata=%h err=%b want rdata=%h err=%b",
                     dm_rdata_o, err_o, e.rdata, e.err);
          end
        end
      end
      if (!if_ack_o && !dm_ack_o) begin
        checks++;
        if (err_o !== 1'b0) begin
          failures++;
          $display("FAIL err_idle: got %b want 0", err_o);
        end
      end
    end
  end

  task automatic wait_ack(input bit is_dm, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (is_dm ? dm_ack_o : if_ack_o) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout: got no ack want ack within 200 cycles", nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_if(input int gap, input bit hang_ok);
    logic [31:0] a;
    int lat;
    exp_t e;
    repeat (gap) begin @(posedge clk); #1; end
    a = 32'h1000_0000 | ($urandom & 32'h0000_FFFC);
    lat = (hang_ok && $urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 3));
    if_lat_q.push_back(lat);
    e.err = (lat < 0);
    if (lat >= 0) if_prev = memf(a);
    e.rdata = if_prev;
    if_exp_q.push_back(e);
    if_addr_i = a;
    if_req_i = 1'b1;
    wait_ack(1'b0, "if");
    if_req_i = 1'b0;
  endtask

  task automatic do_dm(input int gap, input bit hang_ok, input bit load_only);
    logic [31:0] a;
    bit we;
    int lat;
    exp_t e;
    repeat (gap) begin @(posedge clk); #1; end
    a = 32'h2000_0000 | ($urandom & 32'h0000_FFFC);
    we = !load_only && ($urandom_range(0, 2) == 0);
    lat = (hang_ok && $urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 3));
    dm_lat_q.push_back(lat);
    e.err = (lat < 0);
    if (lat >= 0 && !we) dm_prev = memf(a);
    e.rdata = dm_prev;
    dm_exp_q.push_back(e);
    dm_we_i = we;
    dm_addr_i = a;
    dm_wdata_i = $urandom;
    dm_req_i = 1'b1;
    wait_ack(1'b1, "dm");
    dm_req_i = 1'b0;
  endtask

  initial begin
    exp_t e;
    bit   ok;
    bit   exp_log[7];
    rst_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_en_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== '0) begin
      failures++;
      $display("FAIL reset_mem: got en=%b we=%b addr=%h want 0", mem_en_o, mem_we_o, mem_addr_o);
    end
    checks++;
    if (if_ack_o !== 1'b0 || dm_ack_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack: got %b%b%b want 000", if_ack_o, dm_ack_o, err_o);
    end
    checks++;
    if (if_rdata_o !== '0 || dm_rdata_o !== '0) begin
      failures++;
      $display("FAIL reset_rdata: got %h/%h want 0", if_rdata_o, dm_rdata_o);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // async reset during a hung load, then re-arbitration of the held request
    dm_lat_q.push_back(-1);
    dm_lat_q.push_back(3);
    dm_prev = memf(32'h2000_0040);
    e.err = 1'b0;
    e.rdata = dm_prev;
    dm_exp_q.push_back(e);
    dm_we_i = 1'b0;
    dm_addr_i = 32'h2000_0040;
    dm_req_i = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (mem_en_o) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rst_grant: got mem_en_o=0 want 1");
    end
    repeat (3) @(posedge clk);
    #3;
    rst_i = 1'b1;
    #1;
    checks++;
    if (mem_en_o !== 1'b0 || dm_ack_o !== 1'b0 || if_ack_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL async_rst: got en=%b acks=%b%b err=%b want 0",
               mem_en_o, if_ack_o, dm_ack_o, err_o);
    end
    ref_streak = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_i = 1'b0;
    wait_ack(1'b1, "rst_dm");
    dm_req_i = 1'b0;

    // IF held while DM streams six loads
    gnt_log.delete();
    fork
      do_if(0, 1'b0);
      begin
        for (int k = 0; k < 6; k++) do_dm(0, 1'b0, 1'b1);
      end
    join
    exp_log = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ok = (gnt_log.size() == 7);
    for (int i = 0; i < 7; i++) begin
      if (ok && gnt_log[i] != exp_log[i]) ok = 0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL streak_order: got %0d grants (%p) want DDDDIDD",
               gnt_log.size(), gnt_log);
    end

    // randomised traffic including hung accesses
    fork
      begin
        for (int k = 0; k < 30; k++) do_if($urandom_range(0, 5), 1'b1);
      end
      begin
        for (int k = 0; k < 30; k++) do_dm($urandom_range(0, 2), 1'b1, 1'b0);
      end
    join

    repeat (5) @(posedge clk);
    checks++;
    if (if_exp_q.size() != 0 || dm_exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d pending want 0/0",
               if_exp_q.size(), dm_exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
